// File: rtl/gaus_pkg.sv
// rtl/gaus_pkg.sv - shared types and constants for the 3x3 Gaussian stream filter
package gaus_pkg;

  // Frame-level control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } gaus_state_t;

  // Kernel [1 2 1; 2 4 2; 1 2 1] / 16
  localparam int K_CORNER = 1;
  localparam int K_EDGE   = 2;
  localparam int K_CENTRE = 4;
  localparam int K_SHIFT  = 4;
  localparam int K_HALF   = 8;

  // Accumulator width: weights sum to 16, so four extra bits never overflow
  function automatic int acc_w(input int data_width);
    return data_width + 4;
  endfunction

endpackage

// File: rtl/line_buf_ram.sv
// rtl/line_buf_ram.sv - simple dual-port line memory, registered read
module line_buf_ram
  import gaus_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int DATA_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_W];

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // One-cycle registered read port
  always_ff @(posedge i_clk) begin
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/gaus_filter3x3_axis.sv
// rtl/gaus_filter3x3_axis.sv - 3x3 Gaussian blur on a grey pixel stream, raw centre aligned; GAUS_ROUND_EN selects round-half-up
module gaus_filter3x3_axis
  import gaus_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int LINE_W     = 1920,
  parameter int FRAME_H    = 1080,
  parameter int ADDR_W     = 11
) (
  input  logic                  pixel_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [DATA_WIDTH-1:0] m_axis_raw,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast
);

  localparam int                ACC_W     = acc_w(DATA_WIDTH);
  localparam int                ROW_W     = $clog2(FRAME_H + 2);
  localparam logic [ADDR_W-1:0] COL_ZERO  = '0;
  localparam logic [ADDR_W-1:0] COL_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(LINE_W - 1);
  localparam logic [ROW_W-1:0]  ROW_ZERO  = '0;
  localparam logic [ROW_W-1:0]  ROW_ONE   = ROW_W'(1);
  localparam logic [ROW_W-1:0]  ROW_TWO   = ROW_W'(2);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(FRAME_H - 1);
  localparam logic [ROW_W-1:0]  ROW_FLEND = ROW_W'(FRAME_H + 1);

  gaus_state_t           r_state;
  logic [ADDR_W-1:0]     r_col;
  logic [ROW_W-1:0]      r_row;
  logic                  w_flush, w_sof, w_beat, w_primed;
  logic                  w_border, w_first, w_last;
  logic [DATA_WIDTH-1:0] w_din, w_lb0_q, w_lb1_q;
  logic [ADDR_W-1:0]     w_pos_col, w_nxt_col, w_rd_addr, w_ctr_col;
  logic [ROW_W-1:0]      w_pos_row, w_nxt_row, w_ctr_row;
  logic [DATA_WIDTH-1:0] r_win [3][3];
  logic                  r_v1, r_b1, r_f1, r_l1;
  logic                  r_v2, r_b2, r_f2, r_l2;
  logic [ACC_W-1:0]      r_sum, w_sum, w_corner, w_edge, w_rnd;
  logic [DATA_WIDTH-1:0] r_raw2, w_res;
  logic                  w_unused_tlast;

  // Line ends come from the column counter, not from tlast
  assign w_unused_tlast = s_axis_tlast;

  assign s_axis_tready = (r_state != FLUSH);
  assign w_flush       = (r_state == FLUSH);
  assign w_sof         = s_axis_tvalid & s_axis_tready & s_axis_tuser;
  assign w_beat        = w_flush | w_sof | (s_axis_tvalid & (r_state == RUN));
  assign w_din         = w_flush ? '0 : s_axis_tdata;
  assign w_pos_col     = w_sof ? COL_ZERO : r_col;
  assign w_pos_row     = w_sof ? ROW_ZERO : r_row;
  // Read one column ahead on a beat so the RAM output lines up with the next beat
  assign w_rd_addr     = w_beat ? w_nxt_col : r_col;
  assign w_primed      = (w_pos_row >= ROW_TWO) | ((w_pos_row == ROW_ONE) & (w_pos_col != COL_ZERO));
  assign w_border      = (w_ctr_row == ROW_ZERO) | (w_ctr_row == ROW_LAST) |
                         (w_ctr_col == COL_ZERO) | (w_ctr_col == COL_LAST);
  assign w_first       = (w_ctr_row == ROW_ZERO) & (w_ctr_col == COL_ZERO);
  assign w_last        = (w_ctr_col == COL_LAST);

  // Position after this beat, and the centre of the window this beat completes
  always_comb begin
    w_nxt_col = w_pos_col + COL_ONE;
    w_nxt_row = w_pos_row;
    w_ctr_col = w_pos_col - COL_ONE;
    w_ctr_row = w_pos_row - ROW_ONE;
    if (w_pos_col == COL_LAST) begin
      w_nxt_col = COL_ZERO;
      w_nxt_row = w_pos_row + ROW_ONE;
    end
    if (w_pos_col == COL_ZERO) begin
      w_ctr_col = COL_LAST;
      w_ctr_row = w_pos_row - ROW_TWO;
    end
  end

  line_buf_ram #(.ADDR_W(ADDR_W), .DATA_WIDTH(DATA_WIDTH)) u_lb0 (
    .i_clk(pixel_clk), .i_we(w_beat), .i_waddr(w_pos_col), .i_wdata(w_din),
    .i_raddr(w_rd_addr), .o_rdata(w_lb0_q)
  );

  line_buf_ram #(.ADDR_W(ADDR_W), .DATA_WIDTH(DATA_WIDTH)) u_lb1 (
    .i_clk(pixel_clk), .i_we(w_beat), .i_waddr(w_pos_col), .i_wdata(w_lb0_q),
    .i_raddr(w_rd_addr), .o_rdata(w_lb1_q)
  );

  // Frame FSM and input position counters; flush runs LINE_W+1 zero beats
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_col   <= COL_ZERO;
      r_row   <= ROW_ZERO;
    end else if (w_beat) begin
      r_col <= w_nxt_col;
      r_row <= w_nxt_row;
      case (r_state)
        IDLE:  r_state <= RUN;
        RUN:   if (!w_sof && (r_row == ROW_LAST) && (r_col == COL_LAST)) r_state <= FLUSH;
        FLUSH: if (r_row == ROW_FLEND) begin
                 r_state <= IDLE;
                 r_col   <= COL_ZERO;
                 r_row   <= ROW_ZERO;
               end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Shift a new column {row-2, row-1, row} into the window and tag its centre
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) r_win[i][j] <= '0;
      r_v1 <= 1'b0;
      r_b1 <= 1'b0;
      r_f1 <= 1'b0;
      r_l1 <= 1'b0;
    end else begin
      r_v1 <= w_beat & w_primed;
      if (w_beat) begin
        for (int i = 0; i < 3; i++) begin
          r_win[i][0] <= r_win[i][1];
          r_win[i][1] <= r_win[i][2];
        end
        r_win[0][2] <= w_lb1_q;
        r_win[1][2] <= w_lb0_q;
        r_win[2][2] <= w_din;
        r_b1 <= w_border;
        r_f1 <= w_first;
        r_l1 <= w_last;
      end
    end
  end

  assign w_corner = ACC_W'(r_win[0][0]) + ACC_W'(r_win[0][2]) + ACC_W'(r_win[2][0]) + ACC_W'(r_win[2][2]);
  assign w_edge   = ACC_W'(r_win[0][1]) + ACC_W'(r_win[1][0]) + ACC_W'(r_win[1][2]) + ACC_W'(r_win[2][1]);
  assign w_sum    = ACC_W'(K_CORNER) * w_corner + ACC_W'(K_EDGE) * w_edge +
                    ACC_W'(K_CENTRE) * ACC_W'(r_win[1][1]);
`ifdef GAUS_ROUND_EN
  assign w_rnd    = r_sum + ACC_W'(K_HALF);
`else
  assign w_rnd    = r_sum;
`endif
  assign w_res    = DATA_WIDTH'(w_rnd >> K_SHIFT);

  // Adder-tree register stage
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_v2   <= 1'b0;
      r_b2   <= 1'b0;
      r_f2   <= 1'b0;
      r_l2   <= 1'b0;
      r_sum  <= '0;
      r_raw2 <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_sum  <= w_sum;
        r_raw2 <= r_win[1][1];
        r_b2   <= r_b1;
        r_f2   <= r_f1;
        r_l2   <= r_l1;
      end
    end
  end

  // Output registers; border centres pass the raw pixel through
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      m_axis_tdata  <= '0;
      m_axis_raw    <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      m_axis_tvalid <= r_v2;
      m_axis_tuser  <= r_v2 & r_f2;
      m_axis_tlast  <= r_v2 & r_l2;
      if (r_v2) begin
        m_axis_tdata <= r_b2 ? r_raw2 : w_res;
        m_axis_raw   <= r_raw2;
      end
    end
  end

endmodule

// File: tb/tb_gaus_filter3x3_axis.sv
// tb/tb_gaus_filter3x3_axis.sv - randomized self-checking bench with a frame-level Gaussian model
module tb_gaus_filter3x3_axis;

  localparam int DW   = 10;
  localparam int LW   = 8;
  localparam int FH   = 6;
  localparam int AW   = 4;
  localparam int NPIX = LW * FH;
`ifdef GAUS_ROUND_EN
  localparam int RND = 8, E_CTR = 256, E_EDGE = 128, E_DIAG = 64;
`else
  localparam int RND = 0, E_CTR = 255, E_EDGE = 127, E_DIAG = 63;
`endif

  logic          pixel_clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tuser = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata, m_axis_raw;
  logic          m_axis_tvalid, m_axis_tuser, m_axis_tlast;

  gaus_filter3x3_axis #(.DATA_WIDTH(DW), .LINE_W(LW), .FRAME_H(FH), .ADDR_W(AW)) dut (
    .pixel_clk(pixel_clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_raw(m_axis_raw), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct { int d; int raw; int u; int l; int cyc; } out_t;
  out_t q[$];
  int   img [FH][LW];
  int   cyc = 0;
  int   n_checks = 0, n_errors = 0;
  int   beat_cnt = 0, beat9_cyc = 0, n_low = 0, k_new = 0;

  always @(posedge pixel_clk) cyc <= cyc + 1;

  always @(negedge pixel_clk)
    if (m_axis_tvalid)
      q.push_back('{int'(m_axis_tdata), int'(m_axis_raw), int'(m_axis_tuser), int'(m_axis_tlast), cyc});

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: weighted 3x3 mean of the stored frame, border pixels pass through
  function automatic int model_pix(input int r, input int c);
    int s;
    s = 0;
    if (r == 0 || r == FH - 1 || c == 0 || c == LW - 1) return img[r][c];
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        s += (2 - (dr < 0 ? -dr : dr)) * (2 - (dc < 0 ? -dc : dc)) * img[r + dr][c + dc];
    return (s + RND) / 16;
  endfunction

  task automatic put_beat(input int d, input bit u, input bit l, input bit gaps);
    int guard;
    guard = 0;
    if (gaps)
      while ($urandom_range(0, 1) == 1 && guard < 8) begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = DW'($urandom);
        @(posedge pixel_clk); #1;
        guard++;
      end
    guard = 0;
    while (!s_axis_tready && guard < 100) begin
      @(posedge pixel_clk); #1;
      guard++;
    end
    if (!s_axis_tready) check_eq("tready_wait", int'(s_axis_tready), 1);
    s_axis_tdata  = DW'(d);
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    @(posedge pixel_clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    beat_cnt++;
    if (beat_cnt == LW + 2) beat9_cyc = cyc;
  endtask

  task automatic send_pixels(input int n, input bit gaps);
    beat_cnt = 0;
    for (int i = 0; i < n; i++)
      put_beat(img[i / LW][i % LW], i == 0, (i % LW) == LW - 1, gaps);
  endtask

  task automatic count_tready_low(output int n);
    n = 0;
    while (!s_axis_tready && n < 50) begin
      n++;
      @(posedge pixel_clk); #1;
    end
  endtask

  task automatic drain();
    repeat (20) @(posedge pixel_clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int start);
    check_eq({tag, "_count"}, q.size() - start, NPIX);
    for (int i = 0; i < NPIX && start + i < q.size(); i++) begin
      int r, c;
      r = i / LW;
      c = i % LW;
      check_eq($sformatf("%s_data[%0d,%0d]", tag, r, c), q[start + i].d, model_pix(r, c));
      check_eq($sformatf("%s_raw[%0d,%0d]", tag, r, c), q[start + i].raw, img[r][c]);
      check_eq($sformatf("%s_tuser[%0d,%0d]", tag, r, c), q[start + i].u, (i == 0) ? 1 : 0);
      check_eq($sformatf("%s_tlast[%0d,%0d]", tag, r, c), q[start + i].l, (c == LW - 1) ? 1 : 0);
    end
  endtask

  task automatic fill_rand();
    for (int r = 0; r < FH; r++)
      for (int c = 0; c < LW; c++) img[r][c] = $urandom_range(0, 1023);
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < FH; r++)
      for (int c = 0; c < LW; c++) img[r][c] = 8 * r + c;
  endtask

  task automatic run_frame(input string tag, input bit gaps);
    q.delete();
    send_pixels(NPIX, gaps);
    count_tready_low(n_low);
    check_eq({tag, "_tready_low"}, n_low, LW + 1);
    drain();
    check_frame(tag, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge pixel_clk);
    #1;
    check_eq("rst_tvalid", int'(m_axis_tvalid), 0);
    check_eq("rst_tdata", int'(m_axis_tdata), 0);
    check_eq("rst_raw", int'(m_axis_raw), 0);
    check_eq("rst_tuser", int'(m_axis_tuser), 0);
    check_eq("rst_tlast", int'(m_axis_tlast), 0);
    check_eq("rst_tready", int'(s_axis_tready), 1);
    rst = 1'b0;
    @(posedge pixel_clk); #1;

    // Flat frame, gapless, plus first-output latency
    for (int r = 0; r < FH; r++)
      for (int c = 0; c < LW; c++) img[r][c] = 100;
    run_frame("flat", 1'b0);
    if (q.size() > 0) check_eq("latency", q[0].cyc - beat9_cyc, 2);

    // Impulse at (2,3)
    for (int r = 0; r < FH; r++)
      for (int c = 0; c < LW; c++) img[r][c] = 0;
    img[2][3] = 1023;
    run_frame("impulse", 1'b0);
    if (q.size() >= NPIX) begin
      check_eq("imp_ctr", q[2 * LW + 3].d, E_CTR);
      check_eq("imp_n", q[1 * LW + 3].d, E_EDGE);
      check_eq("imp_s", q[3 * LW + 3].d, E_EDGE);
      check_eq("imp_w", q[2 * LW + 2].d, E_EDGE);
      check_eq("imp_e", q[2 * LW + 4].d, E_EDGE);
      check_eq("imp_nw", q[1 * LW + 2].d, E_DIAG);
      check_eq("imp_ne", q[1 * LW + 4].d, E_DIAG);
      check_eq("imp_sw", q[3 * LW + 2].d, E_DIAG);
      check_eq("imp_se", q[3 * LW + 4].d, E_DIAG);
    end

    // Ramp, gapless then with random valid gaps
    fill_ramp();
    run_frame("ramp", 1'b0);
    if (q.size() >= NPIX) check_eq("ramp_23", q[2 * LW + 3].d, 19);
    run_frame("ramp_gaps", 1'b1);
    if (q.size() >= NPIX) check_eq("ramp_gaps_23", q[2 * LW + 3].d, 19);

    // Random content with gaps
    for (int f = 0; f < 2; f++) begin
      fill_rand();
      run_frame($sformatf("rand%0d", f), 1'b1);
    end

    // Reset in input row 3, then a clean frame
    fill_rand();
    send_pixels(3 * LW + 3, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("midrst_tvalid", int'(m_axis_tvalid), 0);
    check_eq("midrst_tdata", int'(m_axis_tdata), 0);
    check_eq("midrst_tready", int'(s_axis_tready), 1);
    @(posedge pixel_clk); #1;
    check_eq("midrst_tvalid_held", int'(m_axis_tvalid), 0);
    rst = 1'b0;
    @(posedge pixel_clk); #1;
    fill_rand();
    run_frame("after_rst", 1'b1);

    // Restart with tuser at input row 2 col 5
    fill_ramp();
    send_pixels(2 * LW + 5, 1'b0);
    fill_rand();
    q.delete();
    send_pixels(NPIX, 1'b0);
    drain();
    k_new = -1;
    for (int i = 0; i < q.size(); i++)
      if (k_new < 0 && q[i].u == 1) k_new = i;
    check_eq("restart_tuser_seen", (k_new >= 0) ? 1 : 0, 1);
    check_frame("restart", (k_new < 0) ? 0 : k_new);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
